// File: rtl/weight_memory_compute_address_controller_pkg.sv
// Shared types and helpers for the weight-memory compute address controller:
// address-width derivation, address typedef and the sequencing FSM encoding.
package weight_memory_pkg;

   function automatic int addr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   localparam int DEFAULT_BANK_DEPTH = 8;

   typedef logic [addr_width(DEFAULT_BANK_DEPTH)-1:0] weight_compute_address_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } compute_address_state_e;

endpackage

// File: rtl/weight_memory_compute_address_controller_if.sv
// Compute-port bundle between the layer sequencer / weight memory (slave side)
// and the compute address controller (master side).
interface weight_memory_compute_address_controller_if
   import weight_memory_pkg::*;
#(
   parameter int WEIGHT_BANK_DEPTH           = 8,
   parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 8,
   parameter int PASS_COUNT_WIDTH            = 16
);
   localparam int ADDR_W  = addr_width(WEIGHT_BANK_DEPTH);
   localparam int WORDS_W = $clog2(WEIGHT_BANK_DEPTH + 1);

   logic                                   start;
   logic [ADDR_W-1:0]                      base_address;
   logic [WORDS_W-1:0]                     number_of_words;
   logic [PASS_COUNT_WIDTH-1:0]            number_of_passes;
   logic                                   stall;
   logic [ADDR_W-1:0]                      compute_address [NUMBER_OF_PE_ARRAYS_PER_ROW];
   logic [NUMBER_OF_PE_ARRAYS_PER_ROW-1:0] address_valid;
   logic                                   busy;
   logic                                   done;

   modport master (
      input  start, base_address, number_of_words, number_of_passes, stall,
      output compute_address, address_valid, busy, done
   );

   modport slave (
      output start, base_address, number_of_words, number_of_passes, stall,
      input  compute_address, address_valid, busy, done
   );

endinterface

// File: rtl/weight_memory_compute_address_controller_skew_chain.sv
// N-stage address/valid shift register giving PE array i the stage-0 stream
// i cycles late; the whole chain freezes when enable is low.
module compute_address_skew_chain #(
   parameter int ADDR_W = 3,
   parameter int STAGES = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [ADDR_W-1:0] in_address,
   input  logic              in_valid,
   output logic [ADDR_W-1:0] stage_address [STAGES],
   output logic [STAGES-1:0] stage_valid
);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < STAGES; i++) stage_address[i] <= '0;
         stage_valid <= '0;
      end else if (enable) begin
         // stage 0 keeps its last address while idle so only valid drops
         if (in_valid) stage_address[0] <= in_address;
         stage_valid[0] <= in_valid;
         for (int i = 1; i < STAGES; i++) begin
            stage_address[i] <= stage_address[i-1];
            stage_valid[i]   <= stage_valid[i-1];
         end
      end
   end

endmodule

// File: rtl/weight_memory_compute_address_controller.sv
// Weight-memory compute-port address sequencer: walks W words for P passes,
// optionally skewed per PE array when WEIGHT_COMPUTE_ADDRESS_SKEW_EN is defined.
module weight_memory_compute_address_controller
   import weight_memory_pkg::*;
#(
   parameter int WEIGHT_BANK_DEPTH           = 8,
   parameter int NUMBER_OF_PE_ARRAYS_PER_ROW = 8,
   parameter int PASS_COUNT_WIDTH            = 16
) (
   input logic clk,
   input logic reset,
   weight_memory_compute_address_controller_if.master bus
);
   localparam int ADDR_W  = addr_width(WEIGHT_BANK_DEPTH);
   localparam int WORDS_W = $clog2(WEIGHT_BANK_DEPTH + 1);
   localparam int N       = NUMBER_OF_PE_ARRAYS_PER_ROW;
   localparam int CNT_W   = $clog2(N) + 1;
`ifdef WEIGHT_COMPUTE_ADDRESS_SKEW_EN
   localparam int DRAIN_LAST = N - 1;
`else
   localparam int DRAIN_LAST = 0;
`endif
   localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(WEIGHT_BANK_DEPTH);

   // base + offset modulo a depth that need not be a power of two
   function automatic logic [ADDR_W-1:0] wrap_address(input logic [ADDR_W-1:0]  base,
                                                      input logic [WORDS_W-1:0] offset);
      logic [ADDR_W:0] sum;
      sum = {1'b0, base} + {1'b0, ADDR_W'(offset)};
      if (sum >= DEPTH_V) sum = sum - DEPTH_V;
      return sum[ADDR_W-1:0];
   endfunction

   compute_address_state_e      state, state_nxt;
   logic [ADDR_W-1:0]           base_q;
   logic [WORDS_W-1:0]          words_q, word_idx;
   logic [PASS_COUNT_WIDTH-1:0] passes_q, pass_idx;
   logic [CNT_W-1:0]            drain_cnt;
   logic                        zero_pending, done_r;
   logic                        accept, issue, drain_end, zero_job, last_word, last_pass;
   logic [ADDR_W-1:0]           issue_addr;

   assign zero_job   = (bus.number_of_words == '0) || (bus.number_of_passes == '0);
   assign last_word  = (word_idx == words_q - WORDS_W'(1));
   assign last_pass  = (pass_idx == passes_q - PASS_COUNT_WIDTH'(1));
   assign issue_addr = wrap_address(base_q, word_idx);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept && !zero_job) state_nxt = RUN;
         RUN:     if (issue && last_word && last_pass) state_nxt = DRAIN;
         DRAIN:   if (drain_end) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept    = 1'b0;
      issue     = 1'b0;
      drain_end = 1'b0;
      bus.busy  = 1'b0;
      unique case (state)
         IDLE:  accept = bus.start;
         RUN: begin
            issue    = !bus.stall;
            bus.busy = 1'b1;
         end
         DRAIN: begin
            drain_end = !bus.stall && (drain_cnt == CNT_W'(DRAIN_LAST));
            bus.busy  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         base_q       <= '0;
         words_q      <= '0;
         passes_q     <= '0;
         word_idx     <= '0;
         pass_idx     <= '0;
         drain_cnt    <= '0;
         zero_pending <= 1'b0;
         done_r       <= 1'b0;
      end else begin
         zero_pending <= accept && zero_job;
         if (accept) begin
            base_q   <= bus.base_address;
            words_q  <= bus.number_of_words;
            passes_q <= bus.number_of_passes;
            word_idx <= '0;
            pass_idx <= '0;
         end else if (issue) begin
            if (last_word) begin
               word_idx <= '0;
               pass_idx <= pass_idx + PASS_COUNT_WIDTH'(1);
            end else begin
               word_idx <= word_idx + WORDS_W'(1);
            end
         end
         if (issue)                             drain_cnt <= '0;
         else if (state == DRAIN && !bus.stall) drain_cnt <= drain_cnt + CNT_W'(1);
         // a completion seen during stall stays pending until stall releases
         if (zero_pending || drain_end) done_r <= 1'b1;
         else if (!bus.stall)           done_r <= 1'b0;
      end
   end

   assign bus.done = done_r && !bus.stall;

`ifdef WEIGHT_COMPUTE_ADDRESS_SKEW_EN
   logic [ADDR_W-1:0] stage_address [N];
   logic [N-1:0]      stage_valid;

   compute_address_skew_chain #(
      .ADDR_W (ADDR_W),
      .STAGES (N)
   ) u_skew_chain (
      .clk           (clk),
      .reset         (reset),
      .enable        (!bus.stall),
      .in_address    (issue_addr),
      .in_valid      (issue),
      .stage_address (stage_address),
      .stage_valid   (stage_valid)
   );

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.compute_address[g] = stage_address[g];
      assign bus.address_valid[g]   = stage_valid[g];
   end
`else
   logic [ADDR_W-1:0] addr_p0;
   logic              vld_p0;

   // stage 0: single register broadcast to every PE array
   always_ff @(posedge clk) begin
      if (reset) begin
         addr_p0 <= '0;
         vld_p0  <= 1'b0;
      end else if (!bus.stall) begin
         vld_p0 <= issue;
         if (issue) addr_p0 <= issue_addr;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign bus.compute_address[g] = addr_p0;
      assign bus.address_valid[g]   = vld_p0;
   end
`endif

endmodule
